// File: rtl/boid_frame_writer_pkg.sv
// boid_frame_writer_pkg: shared boids display geometry, scan sizing and frame-writer state encoding
package boid_frame_writer_pkg;
  localparam int VIDEO_WIDTH = 640;
  localparam int VIDEO_HEIGHT = 480;
  localparam int PIXEL_COUNT = VIDEO_WIDTH * VIDEO_HEIGHT;
  localparam int ADDR_WIDTH = $clog2(PIXEL_COUNT);
  localparam int MAX_BOIDS = 16;
  localparam int BITS_FOR_BOIDS = $clog2(MAX_BOIDS);
  typedef enum logic [2:0] {ST_IDLE, ST_CLEAR, ST_SCAN, ST_DRAIN, ST_DONE} state_t;
endpackage

// File: rtl/boid_frame_writer_if.sv
// boid_frame_writer_if: boid position fetch and display-memory write bus
interface boid_frame_writer_if #(
  parameter int BITS_FOR_BOIDS = boid_frame_writer_pkg::BITS_FOR_BOIDS,
  parameter int ADDR_WIDTH = boid_frame_writer_pkg::ADDR_WIDTH
);
  logic [BITS_FOR_BOIDS-1:0] boid_sel;
  logic [9:0] boid_x;
  logic [8:0] boid_y;
  logic clear_pulse;
  logic wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  modport master (output boid_sel, clear_pulse, wr_en, wr_addr, input boid_x, boid_y);
  modport slave (input boid_sel, clear_pulse, wr_en, wr_addr, output boid_x, boid_y);
endinterface

// File: rtl/boid_frame_writer_pixel_addr_calc.sv
// pixel_addr_calc: registered y*width+x address with on-screen qualified valid
module pixel_addr_calc #(
  parameter int VIDEO_WIDTH = boid_frame_writer_pkg::VIDEO_WIDTH,
  parameter int VIDEO_HEIGHT = boid_frame_writer_pkg::VIDEO_HEIGHT,
  parameter int ADDR_WIDTH = boid_frame_writer_pkg::ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  en_i,
  input  logic [9:0]            x_i,
  input  logic [8:0]            y_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  vld_o
);
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic vld_q, vld_d;
  always_comb begin
    vld_d = en_i && int'(x_i) < VIDEO_WIDTH && int'(y_i) < VIDEO_HEIGHT;
    addr_d = vld_d ? ADDR_WIDTH'(y_i) * ADDR_WIDTH'(VIDEO_WIDTH) + ADDR_WIDTH'(x_i) : '0;
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr_q <= '0;
      vld_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      vld_q <= vld_d;
    end
  end
  assign addr_o = addr_q;
  assign vld_o = vld_q;
endmodule

// File: rtl/boid_frame_writer.sv
// boid_frame_writer: per frame, clears display memory then plots every on-screen boid
module boid_frame_writer #(
  parameter int MAX_BOIDS = boid_frame_writer_pkg::MAX_BOIDS,
  parameter int BITS_FOR_BOIDS = boid_frame_writer_pkg::BITS_FOR_BOIDS,
  parameter int VIDEO_WIDTH = boid_frame_writer_pkg::VIDEO_WIDTH,
  parameter int VIDEO_HEIGHT = boid_frame_writer_pkg::VIDEO_HEIGHT,
  parameter int ADDR_WIDTH = boid_frame_writer_pkg::ADDR_WIDTH
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic                        screen_end,
  output logic                        busy,
  output logic                        frame_done,
  output logic [7:0]                  overrun_cnt,
  boid_frame_writer_if.master         bus
);
  import boid_frame_writer_pkg::state_t, boid_frame_writer_pkg::ST_IDLE, boid_frame_writer_pkg::ST_CLEAR,
         boid_frame_writer_pkg::ST_SCAN, boid_frame_writer_pkg::ST_DRAIN, boid_frame_writer_pkg::ST_DONE;
  state_t state_q, state_d;
  logic [BITS_FOR_BOIDS-1:0] sel_q, sel_d;
  logic [7:0] ovr_q, ovr_d;
  logic frame_done_q, last_sel;
  assign last_sel = sel_q == BITS_FOR_BOIDS'(MAX_BOIDS - 1);
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = screen_end ? ST_CLEAR : ST_IDLE;
      ST_CLEAR: state_d = ST_SCAN;
      ST_SCAN:  state_d = last_sel ? ST_DRAIN : ST_SCAN;
      ST_DRAIN: state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
    sel_d = (state_q == ST_SCAN && !last_sel) ? sel_q + 1'b1 : '0;
    ovr_d = (screen_end && state_q != ST_IDLE && ovr_q != 8'hFF) ? ovr_q + 8'd1 : ovr_q;
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      sel_q <= '0;
      ovr_q <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      ovr_q <= ovr_d;
      frame_done_q <= state_q == ST_DONE;
    end
  end
  // position sampled while boid_sel is presented; write lands one cycle later
  pixel_addr_calc #(
    .VIDEO_WIDTH(VIDEO_WIDTH),
    .VIDEO_HEIGHT(VIDEO_HEIGHT),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_calc (
    .clock(clock),
    .resetn(resetn),
    .en_i(state_q == ST_SCAN),
    .x_i(bus.boid_x),
    .y_i(bus.boid_y),
    .addr_o(bus.wr_addr),
    .vld_o(bus.wr_en)
  );
  assign bus.boid_sel = sel_q;
  assign bus.clear_pulse = state_q == ST_CLEAR;
  assign busy = state_q != ST_IDLE;
  assign frame_done = frame_done_q;
  assign overrun_cnt = ovr_q;
endmodule

// File: tb/tb_boid_frame_writer.sv
// tb_boid_frame_writer: scoreboard bench for frame timing, addressing, overrun and reset abort
module tb_boid_frame_writer;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic screen_end = 1'b0;
  logic busy, frame_done;
  logic [7:0] overrun_cnt;
  logic [9:0] bx [16];
  logic [8:0] by [16];
  boid_frame_writer_if bus ();
  assign bus.boid_x = bx[bus.boid_sel];
  assign bus.boid_y = by[bus.boid_sel];
  boid_frame_writer dut (
    .clock(clock),
    .resetn(resetn),
    .screen_end(screen_end),
    .busy(busy),
    .frame_done(frame_done),
    .overrun_cnt(overrun_cnt),
    .bus(bus)
  );
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;
  typedef struct {int c; int a;} wr_t;
  wr_t wr_q[$];
  int cl_q[$];
  int fd_q[$];
  int checks = 0;
  int errors = 0;
  int ov_exp = 0;
  task automatic chk(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", n, act, exp, cyc);
    end
  endtask
  // monitor: every DUT event pops its expectation
  always @(negedge clock) begin
    wr_t e;
    if (bus.wr_en) begin
      if (wr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0d at cycle %0d, none expected", bus.wr_addr, cyc);
      end else begin
        e = wr_q.pop_front();
        chk("write_cycle", cyc, e.c);
        chk("write_addr", int'(bus.wr_addr), e.a);
      end
    end
    if (bus.clear_pulse) begin
      if (cl_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_clear: at cycle %0d, none expected", cyc);
      end else chk("clear_cycle", cyc, cl_q.pop_front());
    end
    if (frame_done) begin
      if (fd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame_done: at cycle %0d, none expected", cyc);
      end else chk("frame_done_cycle", cyc, fd_q.pop_front());
    end
  end
  task automatic tick(int n);
    repeat (n) @(posedge clock);
    #2;
  endtask
  task automatic push_frame(int t0);
    cl_q.push_back(t0 + 1);
    for (int k = 0; k < 16; k++)
      if (int'(bx[k]) < 640 && int'(by[k]) < 480)
        wr_q.push_back('{c: t0 + 3 + k, a: int'(by[k]) * 640 + int'(bx[k])});
    fd_q.push_back(t0 + 20);
  endtask
  task automatic kick();
    screen_end = 1'b1;
    push_frame(cyc);
    tick(1);
    screen_end = 1'b0;
  endtask
  task automatic run_frame();
    kick();
    tick(19);
  endtask
  task automatic check_zero(string tag);
    chk({tag, "_boid_sel"}, int'(bus.boid_sel), 0);
    chk({tag, "_clear_pulse"}, int'(bus.clear_pulse), 0);
    chk({tag, "_wr_en"}, int'(bus.wr_en), 0);
    chk({tag, "_wr_addr"}, int'(bus.wr_addr), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_frame_done"}, int'(frame_done), 0);
    chk({tag, "_overrun"}, int'(overrun_cnt), 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    for (int k = 0; k < 16; k++) begin
      bx[k] = '0;
      by[k] = '0;
    end
    tick(3);
    check_zero("reset");
    resetn = 1'b1;
    tick(2);
    // all boids at origin: 16 writes to address 0
    kick();
    chk("busy_in_clear", int'(busy), 1);
    tick(6);
    chk("boid_sel_5", int'(bus.boid_sel), 5);
    tick(12);
    chk("busy_in_done", int'(busy), 1);
    tick(1);
    chk("busy_after_done", int'(busy), 0);
    chk("boid_sel_idle", int'(bus.boid_sel), 0);
    bx[3] = 10'd700; by[3] = 9'd5;
    bx[4] = 10'd10;  by[4] = 9'd480;
    bx[5] = 10'd639; by[5] = 9'd479;
    bx[6] = 10'd640; by[6] = 9'd0;
    bx[7] = 10'd0;   by[7] = 9'd479;
    bx[8] = 10'd1;   by[8] = 9'd1;
    bx[15] = 10'd123; by[15] = 9'd45;
    run_frame();
    run_frame();
    kick();
    tick(9);
    screen_end = 1'b1;
    ov_exp = ov_exp + 1;
    tick(1);
    screen_end = 1'b0;
    chk("overrun_one", int'(overrun_cnt), ov_exp);
    tick(10);
    run_frame();
    chk("overrun_kept", int'(overrun_cnt), ov_exp);
    kick();
    tick(7);
    resetn = 1'b0;
    while (wr_q.size() > 0 && wr_q[$].c >= cyc) void'(wr_q.pop_back());
    while (cl_q.size() > 0 && cl_q[$] >= cyc) void'(cl_q.pop_back());
    while (fd_q.size() > 0 && fd_q[$] >= cyc) void'(fd_q.pop_back());
    ov_exp = 0;
    #1;
    check_zero("abort");
    tick(3);
    resetn = 1'b1;
    tick(12);
    chk("idle_after_abort", int'(busy), 0);
    resetn = 1'b0;
    tick(2);
    resetn = 1'b1;
    kick();
    chk("start_after_release", int'(busy), 1);
    tick(19);
    screen_end = 1'b1;
    for (int f = 0; f < 13; f++) begin
      push_frame(cyc);
      ov_exp = ov_exp + 19;
      tick(20);
    end
    screen_end = 1'b0;
    chk("overrun_247", int'(overrun_cnt), 247);
    chk("overrun_model", int'(overrun_cnt), ov_exp);
    screen_end = 1'b1;
    for (int f = 0; f < 3; f++) begin
      push_frame(cyc);
      tick(20);
    end
    screen_end = 1'b0;
    chk("overrun_saturated", int'(overrun_cnt), 255);
    tick(3);
    chk("writes_outstanding", wr_q.size(), 0);
    chk("clears_outstanding", cl_q.size(), 0);
    chk("frame_dones_outstanding", fd_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
